bird_control: RTL
=================

BIRD_CONTROL -- requirements
Module: bird_control

Interface
REQ-001 Parameter ROWS, default 16, number of display rows; row 0 is the top row.
REQ-002 Parameter START_ROW, default 8, bird row after reset and after a restart.
REQ-003 Parameter FLAP_RISE, default 2, rows climbed per flap tick.
REQ-004 Parameter MAX_FALL, default 2, maximum rows fallen per tick.
REQ-005 clk  input  1  single system clock; all state changes on posedge clk.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 incr  input  1  one-cycle game-tick pulse from the tick counter.
REQ-008 flap  input  1  raw player key, level, active-high, synchronous to clk.
REQ-009 hit  input  1  pipe-collision flag from the pipe/collision stage, level.
REQ-010 bird_row  output  $clog2(ROWS)  current bird row.
REQ-011 playing  output  1  high in PLAY.
REQ-012 game_over  output  1  high in DEAD.

Function
REQ-013 flap SHALL be edge-detected; one rising edge SHALL produce exactly one flap event, regardless of hold length.
REQ-014 A flap event SHALL set flap_pending; flap_pending SHALL clear on the next incr consumed in PLAY, on any state change, and on reset.
REQ-015 The FSM SHALL have exactly three states: IDLE, PLAY and DEAD.
REQ-016 IDLE: bird_row SHALL hold START_ROW, fall_vel = 0, and incr SHALL be ignored.
REQ-017 IDLE: a flap event SHALL move the FSM to PLAY on the next cycle, with flap_pending cleared.
REQ-018 PLAY: on an incr cycle with flap_pending or a same-cycle flap event, bird_row SHALL become max(bird_row - FLAP_RISE, 0) and fall_vel SHALL become 0.
REQ-019 PLAY: on an incr cycle without a flap, fall_vel SHALL become min(fall_vel + 1, MAX_FALL), and bird_row SHALL become bird_row + the new fall_vel.
REQ-020 Floor: if bird_row + new fall_vel > ROWS-1, bird_row SHALL become ROWS-1 and the FSM SHALL go to DEAD.
REQ-021 The floor compare SHALL use a width of at least $clog2(ROWS)+2 bits so the sum cannot wrap.
REQ-022 Ceiling: the climb SHALL saturate at row 0, with no death.
REQ-023 PLAY: hit high SHALL move the FSM to DEAD on the next cycle.
REQ-024 hit SHALL take priority over a same-cycle incr; bird_row SHALL NOT move in that cycle.
REQ-025 DEAD: bird_row and fall_vel SHALL hold, and incr and hit SHALL be ignored.
REQ-026 DEAD: a flap event SHALL return the FSM to IDLE with bird_row = START_ROW and fall_vel = 0.
REQ-027 Outside incr cycles, bird_row and fall_vel SHALL hold.
REQ-028 All outputs SHALL be registered, or decoded from registered state only; there is no combinational path from any input to any output.

Reset
REQ-029 reset SHALL override all other inputs in the same cycle.
REQ-030 On reset the block SHALL enter IDLE with bird_row = START_ROW, fall_vel = 0, flap_pending = 0, playing = 0, game_over = 0.
REQ-031 On reset the edge detector's previous-sample register SHALL be set to 1, so a key held through reset yields no flap event.
REQ-032 Reset asserted mid-PLAY or mid-DEAD SHALL take effect on the next posedge.

Structure
REQ-033 Package bird_pkg SHALL hold the state enum (IDLE, PLAY, DEAD) and the default constants ROWS, START_ROW, FLAP_RISE and MAX_FALL.
REQ-034 The flap edge detection SHALL be a separate sub-module, edge_detect (clk, reset, in, pulse).
REQ-035 The FSM and row/velocity datapath SHALL live in bird_control.

Verification
REQ-036 Reset, then 5 incr pulses with no flap -> bird_row = 8, playing = 0 throughout.
REQ-037 Flap edge, then incr pulses, no further flap -> playing = 1; rows 9, 11, 13, 15, then DEAD with bird_row = 15 and game_over = 1 on the following tick (sum 17 > 15).
REQ-038 In PLAY at row 1, flap then incr -> bird_row = 0 and fall_vel = 0; a second flap+incr keeps row 0 and the FSM stays in PLAY.
REQ-039 In PLAY, flap held high for 10 cycles across 3 incr pulses -> exactly one climb of 2 rows, then falls of 1 and 2 rows.
REQ-040 In PLAY, hit and incr in the same cycle -> DEAD next cycle and bird_row unchanged; a later flap -> IDLE with bird_row = 8.
REQ-041 Reset asserted mid-PLAY while flap is held -> IDLE, bird_row = 8, and no flap event after reset releases until flap drops and rises again.

Source files
------------

// File: rtl/bird_pkg.sv
// Shared definitions for the bird controller: FSM state encoding and the
// default playfield / motion constants.
package bird_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DEAD = 2'd2
    } state_t;

    localparam int ROWS      = 16;
    localparam int START_ROW = 8;
    localparam int FLAP_RISE = 2;
    localparam int MAX_FALL  = 2;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for the flap key: one pulse per low-to-high transition.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic pulse
);

    logic prev;

    // Previous sample starts high so a key held through reset never fires.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev <= 1'b1;
        end else begin
            prev <= in;
        end
    end

    assign pulse = in & ~prev;

endmodule

// File: rtl/bird_control.sv
// Bird motion FSM: IDLE / PLAY / DEAD with flap climbs, gravity falls,
// floor death and collision death. Outputs decode registered state only.
module bird_control #(
    parameter int ROWS      = bird_pkg::ROWS,
    parameter int START_ROW = bird_pkg::START_ROW,
    parameter int FLAP_RISE = bird_pkg::FLAP_RISE,
    parameter int MAX_FALL  = bird_pkg::MAX_FALL
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    incr,
    input  logic                    flap,
    input  logic                    hit,
    output logic [$clog2(ROWS)-1:0] bird_row,
    output logic                    playing,
    output logic                    game_over
);

    import bird_pkg::*;

    localparam int RW = $clog2(ROWS);
    localparam int SW = RW + 2;
    localparam logic [RW-1:0] START = RW'(START_ROW);
    localparam logic [RW-1:0] LAST  = RW'(ROWS - 1);

    state_t          state, state_n;
    logic [RW-1:0]   row_n;
    logic [RW-1:0]   fall_vel, vel_n, fall_inc;
    logic            pending, pend_n;
    logic            flap_ev;
    logic [SW-1:0]   sum;

    // Climb saturates at the top row instead of wrapping.
    function automatic logic [RW-1:0] climb(input logic [RW-1:0] row);
        if ({2'b00, row} < SW'(FLAP_RISE)) begin
            return '0;
        end
        return RW'({2'b00, row} - SW'(FLAP_RISE));
    endfunction

    function automatic logic [RW-1:0] accel(input logic [RW-1:0] vel);
        if (vel >= RW'(MAX_FALL)) begin
            return RW'(MAX_FALL);
        end
        return vel + RW'(1);
    endfunction

    edge_detect u_flap_edge (
        .clk   (clk),
        .reset (reset),
        .in    (flap),
        .pulse (flap_ev)
    );

    always_comb begin
        state_n  = state;
        row_n    = bird_row;
        vel_n    = fall_vel;
        pend_n   = pending;
        fall_inc = accel(fall_vel);
        sum      = {2'b00, bird_row} + {2'b00, fall_inc};
        case (state)
            IDLE: begin
                row_n  = START;
                vel_n  = '0;
                pend_n = 1'b0;
                if (flap_ev) begin
                    state_n = PLAY;
                end
            end
            PLAY: begin
                if (hit) begin
                    state_n = DEAD;
                    pend_n  = 1'b0;
                end else if (incr) begin
                    pend_n = 1'b0;
                    if (pending || flap_ev) begin
                        row_n = climb(bird_row);
                        vel_n = '0;
                    end else begin
                        vel_n = fall_inc;
                        // Wide sum so a low bird plus velocity cannot wrap past the floor.
                        if (sum > SW'(ROWS - 1)) begin
                            row_n   = LAST;
                            state_n = DEAD;
                        end else begin
                            row_n = RW'(sum);
                        end
                    end
                end else if (flap_ev) begin
                    pend_n = 1'b1;
                end
            end
            DEAD: begin
                pend_n = 1'b0;
                if (flap_ev) begin
                    state_n = IDLE;
                    row_n   = START;
                    vel_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                row_n   = START;
                vel_n   = '0;
                pend_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            bird_row <= START;
            fall_vel <= '0;
            pending  <= 1'b0;
        end else begin
            state    <= state_n;
            bird_row <= row_n;
            fall_vel <= vel_n;
            pending  <= pend_n;
        end
    end

    assign playing   = (state == PLAY);
    assign game_over = (state == DEAD);

endmodule
